// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results in one cycle and blocks on loads until the data word returns.
// Optional retired-instruction counter output enabled by defining WB_INSTRET_EN.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_ins,
    input  logic [31:0] ex_alu,
    input  logic        ex_reg_w_en,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_val,
`ifdef WB_INSTRET_EN
    output logic [31:0] instret,
`endif
    output logic        stall
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t      state_q, state_d;
    logic        ex_ready_q, ex_ready_d;
    logic        wb_en_q, wb_en_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic [31:0] wb_val_q, wb_val_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic        retire;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        unused_ins;

    assign opcode     = ex_ins[6:0];
    assign rd         = ex_ins[11:7];
    assign funct3     = ex_ins[14:12];
    assign unused_ins = &{1'b0, ex_ins[31:15]};

    // Undefined funct3 codes fall through to the full-word case.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b100:  load_extract = {24'd0, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b101:  load_extract = {16'd0, h};
            default: load_extract = word;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        wb_en_d    = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_val_d   = wb_val_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ld_rd_d    = ld_rd_q;
        ld_f3_d    = ld_f3_q;
        ld_off_d   = ld_off_q;
        retire     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (opcode == OP_LOAD) begin
                        ld_rd_d    = rd;
                        ld_f3_d    = funct3;
                        ld_off_d   = ex_alu[1:0];
                        mem_req_d  = 1'b1;
                        mem_addr_d = {ex_alu[31:2], 2'b00};
                        state_d    = LOAD_WAIT;
                    end else begin
                        retire  = 1'b1;
                        wb_en_d = ex_reg_w_en && (opcode != OP_STORE) &&
                                  (opcode != OP_BRANCH) && (rd != 5'd0);
                        // Result registers only move on an actual write so they hold otherwise.
                        if (wb_en_d) begin
                            wb_reg_d = rd;
                            wb_val_d = ex_alu;
                        end
                    end
                end
            end
            LOAD_WAIT: begin
                if (mem_rvalid) begin
                    retire    = 1'b1;
                    wb_en_d   = (ld_rd_q != 5'd0);
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (wb_en_d) begin
                        wb_reg_d = ld_rd_q;
                        wb_val_d = load_extract(ld_f3_q, ld_off_q, mem_rdata);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ex_ready_d = (state_d == IDLE);
    end

`ifdef WB_INSTRET_EN
    logic [31:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q;
        if (retire) instret_d = instret_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) instret_q <= 32'd0;
        else      instret_q <= instret_d;
    end

    assign instret = instret_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ex_ready_q <= 1'b1;
            wb_en_q    <= 1'b0;
            wb_reg_q   <= 5'd0;
            wb_val_q   <= 32'd0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            ld_rd_q    <= 5'd0;
            ld_f3_q    <= 3'd0;
            ld_off_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            ex_ready_q <= ex_ready_d;
            wb_en_q    <= wb_en_d;
            wb_reg_q   <= wb_reg_d;
            wb_val_q   <= wb_val_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ld_rd_q    <= ld_rd_d;
            ld_f3_q    <= ld_f3_d;
            ld_off_q   <= ld_off_d;
        end
    end

    assign ex_ready = ex_ready_q;
    assign stall    = ~ex_ready_q;
    assign wb_en    = wb_en_q;
    assign wb_reg   = wb_reg_q;
    assign wb_val   = wb_val_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected write-backs are queued at issue and matched as wb_en pulses appear.
module tb_wb_stage;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ADD    = 7'b0110011;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_ins;
    logic [31:0] ex_alu;
    logic        ex_reg_w_en;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_val;
    logic        stall;
`ifdef WB_INSTRET_EN
    logic [31:0] instret;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int exp_ret  = 0;
    logic [36:0] sb[$];

    wb_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_ins     (ex_ins),
        .ex_alu     (ex_alu),
        .ex_reg_w_en(ex_reg_w_en),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_en      (wb_en),
        .wb_reg     (wb_reg),
        .wb_val     (wb_val),
`ifdef WB_INSTRET_EN
        .instret    (instret),
`endif
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_instret(input string tag);
`ifdef WB_INSTRET_EN
        chk(tag, instret, exp_ret);
`endif
    endtask

    // Scoreboard: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && wb_en === 1'b1) begin
            logic [36:0] e;
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed wb_reg %0d wb_val 0x%08h expected no write", wb_reg, wb_val);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_wb_reg", {27'd0, wb_reg}, {27'd0, e[36:32]});
                chk("sb_wb_val", wb_val, e[31:0]);
            end
        end
    end

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic wen);
        int w;
        w = 0;
        while (ex_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("issue_ready", {31'd0, ex_ready}, 32'd1);
        ex_valid    = 1'b1;
        ex_ins      = {17'd0, f3, rd, op};
        ex_alu      = alu;
        ex_reg_w_en = wen;
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_val,
                           input int waits, output int stall_cnt);
        issue(OP_LOAD, f3, rd, alu, 1'b1);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, exp_addr);
        sb.push_back({rd, exp_val});
        exp_ret++;
        stall_cnt = int'(stall);
        // Offer a competing instruction while waiting; it must not be taken.
        ex_valid = 1'b1; ex_ins = {17'd0, 3'd0, 5'd4, OP_ADD}; ex_alu = 32'hBAD; ex_reg_w_en = 1'b1;
        repeat (waits) begin
            @(posedge clk); #1;
            stall_cnt += int'(stall);
        end
        ex_valid = 1'b0;
        chk({tag, "_addr_hold"}, mem_addr, exp_addr);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk({tag, "_wb_en"}, {31'd0, wb_en}, 32'd1);
        chk({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
        chk({tag, "_req_low"}, {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        int sc;
        rst = 1'b0; ex_valid = 1'b0; ex_ins = '0; ex_alu = '0; ex_reg_w_en = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_wb_reg", {27'd0, wb_reg}, 32'd0);
        chk("rst_wb_val", wb_val, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk_instret("rst_instret");
        @(posedge clk); #1;
        rst = 1'b1;

        // ALU result, one-cycle pulse, then held values.
        sb.push_back({5'd5, 32'h1234}); exp_ret++;
        issue(OP_ADD, 3'd0, 5'd5, 32'h1234, 1'b1);
        @(negedge clk);
        chk("add_wb_en", {31'd0, wb_en}, 32'd1);
        @(negedge clk);
        chk("add_pulse_end", {31'd0, wb_en}, 32'd0);
        chk("add_hold_reg", {27'd0, wb_reg}, 32'd5);
        chk("add_hold_val", wb_val, 32'h1234);

        // Suppressed writes: store, rd=0, branch, ex_reg_w_en=0 all retire without a strobe.
        issue(OP_STORE, 3'd2, 5'd9, 32'h55, 1'b1);  exp_ret++;
        @(negedge clk); chk("store_no_wb", {31'd0, wb_en}, 32'd0);
        issue(OP_ADD, 3'd0, 5'd0, 32'h66, 1'b1);    exp_ret++;
        @(negedge clk); chk("rd0_no_wb", {31'd0, wb_en}, 32'd0);
        issue(OP_BRANCH, 3'd1, 5'd3, 32'h77, 1'b1); exp_ret++;
        @(negedge clk); chk("branch_no_wb", {31'd0, wb_en}, 32'd0);
        issue(OP_ADD, 3'd0, 5'd8, 32'h88, 1'b0);    exp_ret++;
        @(negedge clk); chk("wen0_no_wb", {31'd0, wb_en}, 32'd0);
        chk_instret("instret_after_alu");

        // mem_rvalid while idle is ignored.
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("idle_rvalid_no_wb", {31'd0, wb_en}, 32'd0);
        chk("idle_rvalid_no_req", {31'd0, mem_req}, 32'd0);

        // Loads.
        do_load("lb", 3'b000, 5'd3, 32'h103, 32'h80FF_FFFF, 32'h100, 32'hFFFF_FF80, 3, sc);
        chk("lb_stall_cycles", sc, 32'd4);
        do_load("lhu", 3'b101, 5'd7, 32'h202, 32'hBEEF_1234, 32'h200, 32'h0000_BEEF, 1, sc);
        do_load("lh", 3'b001, 5'd7, 32'h202, 32'hBEEF_1234, 32'h200, 32'hFFFF_BEEF, 0, sc);
        do_load("lbu", 3'b100, 5'd10, 32'h101, 32'h1122_A3FF, 32'h100, 32'h0000_00A3, 2, sc);
        do_load("lb_l1", 3'b000, 5'd11, 32'h101, 32'h1122_A3FF, 32'h100, 32'hFFFF_FFA3, 0, sc);
        do_load("lh_mis", 3'b001, 5'd12, 32'h203, 32'h7FFF_8000, 32'h200, 32'h0000_7FFF, 1, sc);
        do_load("lh_lo", 3'b001, 5'd12, 32'h201, 32'h7FFF_8000, 32'h200, 32'hFFFF_8000, 0, sc);
        do_load("lw_f3_3", 3'b011, 5'd13, 32'h307, 32'hDEAD_BEEF, 32'h304, 32'hDEAD_BEEF, 1, sc);
        do_load("lw_f3_6", 3'b110, 5'd14, 32'h30A, 32'hCAFE_F00D, 32'h308, 32'hCAFE_F00D, 0, sc);
        do_load("lw_f3_7", 3'b111, 5'd15, 32'h001, 32'h0123_4567, 32'h000, 32'h0123_4567, 0, sc);
        chk_instret("instret_after_loads");

        // Load to x0 retires without a strobe.
        issue(OP_LOAD, 3'b010, 5'd0, 32'h50, 1'b1); exp_ret++;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(posedge clk); #1; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("ld_rd0_no_wb", {31'd0, wb_en}, 32'd0);
        chk("ld_rd0_ready", {31'd0, ex_ready}, 32'd1);
        chk_instret("instret_ld_rd0");

        // Reset in the middle of a load abandons it.
        issue(OP_LOAD, 3'b010, 5'd6, 32'h400, 1'b1);
        @(posedge clk); #1;
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst = 1'b0; exp_ret = 0;
        #1;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_ready", {31'd0, ex_ready}, 32'd1);
        chk("mid_rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("mid_rst_wb_val", wb_val, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
        @(posedge clk); #1; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_no_wb", {31'd0, wb_en}, 32'd0);
        chk("post_rst_req", {31'd0, mem_req}, 32'd0);
        chk("post_rst_ready", {31'd0, ex_ready}, 32'd1);
        chk_instret("post_rst_instret");

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports: clk, rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 ex_valid  in  1  execute-stage result valid this cycle.
REQ-005 ex_ready  out  1  stage accepts ex_* this cycle.
REQ-006 ex_ins  in  32  instruction word; opcode [6:0], rd [11:7], funct3 [14:12].
REQ-007 ex_alu  in  32  ALU result, or effective address for loads.
REQ-008 ex_reg_w_en  in  1  instruction writes rd.
REQ-009 mem_req  out  1  data-memory read request, held until response.
REQ-010 mem_addr  out  32  word-aligned read address.
REQ-011 mem_rvalid  in  1  read data valid (1-cycle pulse).
REQ-012 mem_rdata  in  32  read data word, little-endian.
REQ-013 wb_en  out  1  register-file write strobe.
REQ-014 wb_reg  out  5  destination register.
REQ-015 wb_val  out  32  write-back value.
REQ-016 stall  out  1  upstream pipeline hold (= not ex_ready).

Function
REQ-017 FSM states SHALL be IDLE and LOAD_WAIT; ex_ready=1 only in IDLE.
REQ-018 IDLE, ex_valid=1, opcode not 0000011: next edge register wb_val=ex_alu, wb_reg=rd, wb_en=ex_reg_w_en; latency 1 cycle; stay IDLE.
REQ-019 Opcodes 0100011 (store) and 1100011 (branch) SHALL force wb_en=0 regardless of ex_reg_w_en.
REQ-020 rd=0 SHALL force wb_en=0.
REQ-021 IDLE, ex_valid=1, opcode 0000011: next edge capture rd, funct3, addr[1:0]; set mem_req=1, mem_addr={ex_alu[31:2],2'b00}; go LOAD_WAIT.
REQ-022 LOAD_WAIT: mem_req and mem_addr SHALL hold; ex_* ignored; wb_en=0.
REQ-023 LOAD_WAIT, mem_rvalid=1: next edge drive extracted data on wb_val, wb_en=1 (unless rd=0), mem_req=0, go IDLE; ex_ready returns 1 that same edge.
REQ-024 Extraction by funct3: 000 LB sign-extend byte at lane addr[1:0]; 100 LBU zero-extend same; 001 LH sign-extend half at lane addr[1]; 101 LHU zero-extend same; 010 LW full word.
REQ-025 Misaligned: LH/LHU use addr[1] only (addr[0] ignored); LW ignores addr[1:0]; no trap.
REQ-026 funct3 011, 110, 111 on a load SHALL be treated as LW.
REQ-027 wb_en SHALL be a 1-cycle pulse per retiring instruction, else 0; wb_reg/wb_val hold last values when wb_en=0.
REQ-028 mem_rvalid in IDLE SHALL be ignored.
REQ-029 No timeout: LOAD_WAIT persists until mem_rvalid.

Reset
REQ-030 rst=0 SHALL asynchronously force: state IDLE, wb_en=0, wb_reg=0, wb_val=0, mem_req=0, mem_addr=0, ex_ready=1 on release.
REQ-031 Reset during LOAD_WAIT SHALL abandon the load; a later mem_rvalid SHALL produce no write.

Configuration
REQ-032 Macro WB_INSTRET_EN defined: output instret (32 bits) SHALL increment by 1 on each retire edge (REQ-018 or REQ-023, including wb_en=0 retires), wrap 0xFFFFFFFF->0, reset to 0.
REQ-033 WB_INSTRET_EN undefined: instret port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-034 ADD rd=5, ex_alu=0x1234, ex_reg_w_en=1 -> next cycle wb_en=1, wb_reg=5, wb_val=0x1234; following cycle wb_en=0.
REQ-035 LB rd=3, ex_alu=0x103; rvalid after 3 cycles, rdata=0x80FFFFFF -> mem_addr=0x100, stall=1 for 4 cycles, then wb_val=0xFFFFFF80, wb_en=1.
REQ-036 LHU rd=7, ex_alu=0x202, rdata=0xBEEF1234 -> wb_val=0x0000BEEF; LH same -> 0xFFFFBEEF.
REQ-037 Store with ex_reg_w_en=1, rd=9; and ADD with rd=0 -> wb_en stays 0 both cycles; instret +2 (macro on).
REQ-038 Reset mid LOAD_WAIT, then mem_rvalid=1 -> mem_req=0, wb_en=0, ex_ready=1, instret=0.
